// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: FSM states,
// id-width derivation and the round-robin one-hot pick.
package mult_arb_pkg;

   // Arbiter FSM: wait for a request, compute, hold the response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Largest supported requester count; the pick function works on
   // vectors of this width and callers zero-pad their valid vector.
   localparam int MAX_REQ  = 16;
   localparam int MAX_ID_W = 4;

   // Width of a requester index (ID_W = $clog2(NUM_REQ), never below 1).
   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Round-robin pick: scan from last+1 upwards, wrapping at num_req-1
   // back to 0, and return the first valid requester as a one-hot vector.
   // Returns all-zero when nothing is valid.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0] valid,
      input int unsigned        num_req,
      input int unsigned        last
   );
      logic [MAX_REQ-1:0] grant;
      logic               found;
      int unsigned        cand;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         // last < num_req and k <= num_req, so one subtraction wraps.
         cand = last + k;
         if (cand >= num_req) cand = cand - num_req;
         if ((k <= num_req) && !found && valid[cand[MAX_ID_W-1:0]]) begin
            grant[cand[MAX_ID_W-1:0]] = 1'b1;
            found                     = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/mult.sv
// Combinational multiplier datapath: out = (in1 * in2) mod 2^WIDTH.
module mult #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out
);

   // Product evaluated in a WIDTH-bit context, so the upper half is dropped.
   assign out = in1 * in2;

endmodule

// File: rtl/mult_arbiter_rr_picker.sv
// Round-robin picker: purely combinational winner selection over a
// valid vector, starting just after the previously granted requester.
module rr_picker
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_any
);

   logic [MAX_REQ-1:0] valid_ext;
   logic [MAX_REQ-1:0] pick;

   // Zero-extend the valid vector to the width the pick function expects.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      valid_ext                = '0;
      valid_ext[NUM_REQ-1:0]   = valid;
   end

   // One-hot winner of the round-robin scan.
   always_comb begin
      pick = rr_pick(valid_ext, NUM_REQ, int'(last_grant));
   end

   assign grant     = pick[NUM_REQ-1:0];
   // Padding bits of pick are always zero, so reducing the whole vector
   // is equivalent to reducing the live part.
   assign grant_any = |pick;

   // Encode the one-hot winner into a requester index.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) grant_idx = ID_W'(i);
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Multiplier arbiter: shares one combinational mult between NUM_REQ
// valid/ready requesters. Round-robin grant latches the winner's operands,
// the product is registered one cycle later and held on a single tagged
// response channel until the consumer takes it. One op in flight at a time.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
   input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]           rsp_data,
   output logic                       busy,
   output logic [CNT_W-1:0]           op_count
);

   localparam int ID_W = id_width(NUM_REQ);

   state_t             state_q,      state_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic [WIDTH-1:0]   op1_q,        op1_d;
   logic [WIDTH-1:0]   op2_q,        op2_d;
   logic [ID_W-1:0]    op_id_q,      op_id_d;
   logic               rsp_valid_q,  rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q,     rsp_id_d;
   logic [WIDTH-1:0]   rsp_data_q,   rsp_data_d;
   logic [CNT_W-1:0]   op_count_q,   op_count_d;

   logic [NUM_REQ-1:0] pick_grant;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic [WIDTH-1:0]   mult_out;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_picker (
      .valid      (req_valid),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .grant_idx  (pick_idx),
      .grant_any  (pick_any)
   );

   // Latched operands feed the shared multiplier; its output is captured
   // in CALC, so the operands only need to be stable for that one cycle.
   mult #(
      .WIDTH (WIDTH)
   ) u_mult (
      .in1 (op1_q),
      .in2 (op2_q),
      .out (mult_out)
   );

   // Next-state logic and combinational req_ready for the arbiter FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      op_id_d      = op_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      op_count_d   = op_count_q;
      req_ready    = '0;

      unique case (state_q)
         IDLE: begin
            // Gated by rst_n so ready is low for the whole reset, even
            // though the state register already reads IDLE.
            req_ready = pick_grant & {NUM_REQ{rst_n}};
            // The picker only selects a valid requester, so a winner
            // is always a completed handshake.
            if (pick_any) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (pick_grant[i]) begin
                     op1_d = req_in1[i*WIDTH +: WIDTH];
                     op2_d = req_in2[i*WIDTH +: WIDTH];
                  end
               end
               op_id_d      = pick_idx;
               last_grant_d = pick_idx;
               state_d      = CALC;
            end
         end

         CALC: begin
            rsp_data_d  = mult_out;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end

         RESP: begin
            // Response held stable until the consumer takes it.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + CNT_W'(1);
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset drops any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         // Pointer starts at the last requester so requester 0 wins first.
         last_grant_q <= ID_W'(NUM_REQ - 1);
         // NOTE: the operand registers are plain flops, not a memory, so
         // they are reset along with everything else.
         op1_q        <= '0;
         op2_q        <= '0;
         op_id_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         op_count_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the
         // pre-edge values, regardless of statement order.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         op_id_q      <= op_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         op_count_q   <= op_count_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign op_count  = op_count_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level model.
module tb_mult_arbiter;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int CW = 4;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   wire  [N-1:0]     req_ready;
   logic [W-1:0]     op1 [N];
   logic [W-1:0]     op2 [N];
   wire  [N*W-1:0]   req_in1;
   wire  [N*W-1:0]   req_in2;
   wire              rsp_valid;
   logic             rsp_ready;
   wire  [IW-1:0]    rsp_id;
   wire  [W-1:0]     rsp_data;
   wire              busy;
   wire  [CW-1:0]    op_count;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: arbiter is free / computing / holding a response.
   bit             m_free;
   bit             m_calc;
   bit             m_rsp;
   int             m_last;
   logic [W-1:0]   m_pend_data;
   int             m_pend_id;
   logic [W-1:0]   m_rsp_data;
   int             m_rsp_id;
   int             m_count;
   int             hs_id;
   int             grant_log[$];
   logic [W-1:0]   data_log[$];

   always #5 clk = ~clk;

   for (genvar i = 0; i < N; i++) begin : g_pack
      assign req_in1[i*W +: W] = op1[i];
      assign req_in2[i*W +: W] = op2[i];
   end

   mult_arbiter #(
      .WIDTH   (W),
      .NUM_REQ (N),
      .CNT_W   (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .op_count  (op_count)
   );

   // First valid requester after 'last', wrapping; -1 if none.
   function automatic int rr_winner(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned wide;
      wide = longint'(a) * longint'(b);
      return wide[W-1:0];
   endfunction

   task automatic model_reset();
      m_free  = 1'b1;
      m_calc  = 1'b0;
      m_rsp   = 1'b0;
      m_last  = N - 1;
      m_count = 0;
   endtask

   // One clock: called at a falling edge with inputs already set; checks
   // outputs against the model, advances the model, waits one cycle.
   task automatic clock_cycle();
      int           w;
      logic [N-1:0] exp_ready;
      #1;
      w = m_free ? rr_winner(req_valid, m_last) : -1;
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;

      tests_run++;
      if (req_ready !== exp_ready) begin
         tests_failed++;
         $display("FAIL cyc_req_ready t=%0t got %b expected %b", $time, req_ready, exp_ready);
      end
      tests_run++;
      if (busy !== !m_free) begin
         tests_failed++;
         $display("FAIL cyc_busy t=%0t got %b expected %b", $time, busy, !m_free);
      end
      tests_run++;
      if (rsp_valid !== m_rsp) begin
         tests_failed++;
         $display("FAIL cyc_rsp_valid t=%0t got %b expected %b", $time, rsp_valid, m_rsp);
      end
      if (m_rsp) begin
         tests_run++;
         if (rsp_data !== m_rsp_data || rsp_id !== IW'(m_rsp_id)) begin
            tests_failed++;
            $display("FAIL cyc_rsp t=%0t got id %0d data %h expected id %0d data %h",
                     $time, rsp_id, rsp_data, m_rsp_id, m_rsp_data);
         end
      end
      tests_run++;
      if (op_count !== CW'(m_count)) begin
         tests_failed++;
         $display("FAIL cyc_op_count t=%0t got %0d expected %0d", $time, op_count, CW'(m_count));
      end

      hs_id = w;
      if (w >= 0) begin
         m_pend_data = ref_product(op1[w], op2[w]);
         m_pend_id   = w;
         m_last      = w;
         m_free      = 1'b0;
         m_calc      = 1'b1;
         grant_log.push_back(w);
      end else if (m_calc) begin
         m_calc     = 1'b0;
         m_rsp      = 1'b1;
         m_rsp_data = m_pend_data;
         m_rsp_id   = m_pend_id;
      end else if (m_rsp && rsp_ready) begin
         m_rsp   = 1'b0;
         m_count = m_count + 1;
         m_free  = 1'b1;
         data_log.push_back(m_rsp_data);
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic drain();
      int n;
      req_valid = '0;
      rsp_ready = 1'b1;
      n = 0;
      while (!m_free && n < 10) begin
         clock_cycle();
         n++;
      end
      tests_run++;
      if (!m_free) begin
         tests_failed++;
         $display("FAIL drain_timeout busy after %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
         op1[i] = '0;
         op2[i] = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got ready %b rsp_valid %b busy %b expected 0 0 0", req_ready, rsp_valid, busy);
      end
      tests_run++;
      if (rsp_id !== '0 || rsp_data !== '0 || op_count !== '0) begin
         tests_failed++;
         $display("FAIL reset_data got id %0d data %h count %0d expected zeros", rsp_id, rsp_data, op_count);
      end
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      op1[0]    = 32'd7;
      op2[0]    = 32'd9;
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      clock_cycle();
      tests_run++;
      if (hs_id !== 0) begin
         tests_failed++;
         $display("FAIL single_grant got %0d expected 0", hs_id);
      end
      req_valid = '0;
      clock_cycle();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd63 || rsp_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL single_rsp got valid %b data %0d id %0d expected 1 63 0", rsp_valid, rsp_data, rsp_id);
      end
      clock_cycle();
      tests_run++;
      if (op_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL single_count got %0d expected 1", op_count);
      end
   endtask

   task automatic test_fairness();
      int           exp_g [6] = '{0, 1, 2, 3, 0, 1};
      logic [W-1:0] exp_d [6] = '{32'd6, 32'd9, 32'd12, 32'd15, 32'd6, 32'd9};
      int n;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         op1[i] = W'(i + 2);
         op2[i] = 32'd3;
      end
      grant_log.delete();
      data_log.delete();
      req_valid = '1;
      rsp_ready = 1'b1;
      n = 0;
      while (data_log.size() < 6 && n < 40) begin
         clock_cycle();
         n++;
      end
      tests_run++;
      if (data_log.size() < 6) begin
         tests_failed++;
         $display("FAIL fair_timeout got %0d responses expected 6", data_log.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            tests_run++;
            if (grant_log[k] !== exp_g[k] || data_log[k] !== exp_d[k]) begin
               tests_failed++;
               $display("FAIL fair_order[%0d] got grant %0d data %0d expected grant %0d data %0d",
                        k, grant_log[k], data_log[k], exp_g[k], exp_d[k]);
            end
         end
      end
      drain();
   endtask

   task automatic test_truncation();
      int n;
      data_log.delete();
      op1[2]    = 32'hFFFF_FFFF;
      op2[2]    = 32'd2;
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      n = 0;
      while (data_log.size() < 1 && n < 10) begin
         clock_cycle();
         if (hs_id == 2) req_valid = '0;
         n++;
      end
      tests_run++;
      if (data_log.size() < 1 || data_log[0] !== 32'hFFFF_FFFE) begin
         tests_failed++;
         $display("FAIL trunc got %0d responses first %h expected fffffffe", data_log.size(),
                  (data_log.size() > 0) ? data_log[0] : 32'hx);
      end
   endtask

   task automatic test_backpressure();
      int           n;
      int           id;
      logic [W-1:0] exp;
      for (int i = 0; i < N; i++) begin
         op1[i] = $urandom;
         op2[i] = $urandom;
      end
      req_valid = '1;
      rsp_ready = 1'b0;
      n = 0;
      while (!m_rsp && n < 10) begin
         clock_cycle();
         n++;
      end
      tests_run++;
      if (!m_rsp) begin
         tests_failed++;
         $display("FAIL bp_timeout no response within %0d cycles", n);
      end
      id  = m_rsp_id;
      exp = ref_product(op1[id], op2[id]);
      for (int k = 0; k < 10; k++) begin
         clock_cycle();
         tests_run++;
         if (rsp_data !== exp || rsp_id !== IW'(id) || req_ready !== '0 || rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d] got data %h id %0d ready %b valid %b expected %h %0d 0000 1",
                     k, rsp_data, rsp_id, req_ready, rsp_valid, exp, id);
         end
      end
      rsp_ready = 1'b1;
      clock_cycle();
      clock_cycle();
      tests_run++;
      if (hs_id !== (id + 1) % N) begin
         tests_failed++;
         $display("FAIL bp_next_grant got %0d expected %0d", hs_id, (id + 1) % N);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      op1[0]    = 32'd11;
      op2[0]    = 32'd13;
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      clock_cycle();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_calc got busy %b expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 ||
          busy !== 1'b0 || op_count !== '0) begin
         tests_failed++;
         $display("FAIL midrst_async got ready %b valid %b data %h id %0d busy %b count %0d expected zeros",
                  req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < N; i++) begin
         op1[i] = $urandom;
         op2[i] = $urandom;
      end
      req_valid = '1;
      clock_cycle();
      tests_run++;
      if (hs_id !== 0) begin
         tests_failed++;
         $display("FAIL midrst_first_grant got %0d expected 0", hs_id);
      end
      req_valid = '0;
      repeat (4) clock_cycle();
   endtask

   task automatic test_op_count_wrap();
      int n;
      apply_reset();
      req_valid = '1;
      rsp_ready = 1'b1;
      n = 0;
      while (m_count < 17 && n < 200) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               op1[i] = $urandom;
               op2[i] = $urandom;
            end
         end
         req_valid = '1;
         clock_cycle();
         n++;
      end
      req_valid = '0;
      tests_run++;
      if (op_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL wrap_count got %0d expected 1 after %0d ops", op_count, m_count);
      end
      drain();
   endtask

   task automatic test_random();
      int waits [N];
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               req_valid[i] = 1'b1;
               op1[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
               op2[i] = $urandom;
            end
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         clock_cycle();
         if (hs_id >= 0) begin
            for (int i = 0; i < N; i++) begin
               if (i == hs_id) waits[i] = 0;
               else if (req_valid[i]) waits[i]++;
            end
            tests_run++;
            if (waits[(hs_id + 1) % N] > N - 1) begin
               tests_failed++;
               $display("FAIL rand_starve req %0d waited %0d ops", (hs_id + 1) % N, waits[(hs_id + 1) % N]);
            end
            req_valid[hs_id] = $urandom_range(0, 1);
            op1[hs_id]       = $urandom;
            op2[hs_id]       = $urandom;
         end
      end
      drain();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_truncation();
      test_backpressure();
      test_reset_mid();
      test_op_count_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
